// File: rtl/gf_mul_pkg.sv
// Shared definitions for the digit-serial GF(2^M) multiplier slice.
// Field/digit sizes and the sequencer state encoding.
package gf_mul_pkg;

   localparam int GF_M     = 16;
   localparam int GF_D     = 4;
   localparam int GF_N     = GF_M / GF_D;
   localparam int GF_CNT_W = $clog2(GF_N);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/gf_digit_shreg.sv
// Parallel-load B register shifting one D-bit digit per clock toward
// index 1; the top digit is the live digit for the array.
module gf_digit_shreg
   import gf_mul_pkg::*;
#(
   parameter int M = GF_M,
   parameter int D = GF_D
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       shift,
   input  logic [1:M] din,
   output logic [1:D] dout
);

   logic [1:M] q;

   // load wins over shift; shifting fills zeros from the low end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= {q[D+1:M], {D{1'b0}}};
      end
   end

   assign dout = q[1:D];

endmodule

// File: rtl/gf_digit_feeder.sv
// Operand sequencer: holds A in parallel and streams B MSB-digit-first
// with first/last framing; back-to-back pairs stream without a bubble.
module gf_digit_feeder
   import gf_mul_pkg::*;
#(
   parameter int M = GF_M,
   parameter int D = GF_D
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:M] a,
   input  logic [1:M] b,
   output logic [1:M] arr_a,
   output logic [1:D] arr_b_dig,
   output logic       dig_valid,
   output logic       dig_first,
   output logic       dig_last,
   output logic       busy
);

   localparam int N     = M / D;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             at_last;
   logic             accept;
   logic             shift;

   assign at_last = (cnt == LAST);

   // state and digit counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next state: load on accept, walk digits, drop to IDLE after the last
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end
         end
         RUN: begin
            if (accept) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else if (at_last) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
      endcase
   end

   // handshake and datapath enables, decoded from state only
   always_comb begin
      in_ready = 1'b0;
      unique case (state)
         IDLE: in_ready = 1'b1;
         RUN:  in_ready = at_last;
      endcase
      accept = in_valid & in_ready;
      shift  = (state == RUN) & ~accept;
   end

   // A is captured on accept and held, also across IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arr_a <= '0;
      end else if (accept) begin
         arr_a <= a;
      end
   end

   // framing flags registered alongside the digit they describe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dig_first <= 1'b0;
         dig_last  <= 1'b0;
      end else begin
         dig_first <= accept;
         dig_last  <= (state_nxt == RUN) & (cnt_nxt == LAST);
      end
   end

   // the shift after the last digit empties the register, so the
   // digit output reads 0 while idle
   gf_digit_shreg #(
      .M (M),
      .D (D)
   ) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .shift (shift),
      .din   (b),
      .dout  (arr_b_dig)
   );

   assign dig_valid = (state == RUN);
   assign busy      = dig_valid;

endmodule

// File: doc/gf_digit_feeder.md
# gf_digit_feeder

Upstream operand sequencer for the digit-serial GF(2^M) systolic multiplier. Accepts one (A, B) operand pair via a valid/ready handshake and presents A in parallel, held stable, while streaming B one D-bit digit per clock, MSB-first, into the first systolic cell row. It supplies the first/last digit framing that the array's cells and delay registers use to clear and close each product. Back-to-back operand pairs stream with no bubble.

## Interface

Parameters:
- M, 16, field degree; operand width.
- D, 4, digit width; M % D == 0 and D < M are required.
- N, M/D, digits per operand; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair a/b is valid.
- in_ready  out  1  feeder accepts the pair this cycle.
- a  in  [1:M]  operand A; index 1 = coefficient x^(M-1).
- b  in  [1:M]  operand B; same ordering.
- arr_a  out  [1:M]  A presented to the array, held for the whole operation.
- arr_b_dig  out  [1:D]  current B digit.
- dig_valid  out  1  arr_b_dig/arr_a carry a live digit.
- dig_first  out  1  digit 0 of an operation; array clears its accumulators.
- dig_last  out  1  digit N-1 of an operation.
- busy  out  1  an operation is in progress (equals dig_valid).

## Operation

- States: IDLE, RUN. Digit counter cnt, width clog2(N), counts 0..N-1.
- Accept = in_valid & in_ready. in_ready = (state==IDLE) | (state==RUN & cnt==N-1). Combinational from state only, never from in_valid.
- On accept: arr_a <= a; B shift register <= b; cnt <= 0; state <= RUN.
- Digit k (k = 0..N-1) = b[k*D+1 : k*D+D]; digit 0 is the most significant.
- In RUN, cnt != N-1: cnt increments, B register shifts left by D, state stays RUN.
- In RUN, cnt == N-1 without accept: state <= IDLE; dig_valid, dig_first, dig_last, arr_b_dig go to 0; arr_a keeps its last value.
- In RUN, cnt == N-1 with accept: new operation loads exactly as from IDLE; no idle cycle.
- in_valid while in_ready low: ignored; the upstream holds a/b stable (standard valid/ready rule, in_valid must not drop before accept).
- All outputs registered except in_ready.

## Timing

- Reset (rst low, async): state IDLE, cnt 0, arr_a 0, arr_b_dig 0, dig_valid/dig_first/dig_last/busy 0, in_ready 1 (IDLE). Takes effect immediately, including mid-operation; the partial operation is dropped, not resumed.
- Accept at edge t: digit 0 with dig_first=1 visible after edge t; digit N-1 with dig_last=1 after edge t+N-1. Operation occupies exactly N cycles.
- dig_first and dig_last are never both 1 (N >= 2).
- Throughput: one operand pair per N cycles at full rate.
- First post-reset accept possible at the first rising edge after rst deasserts.

## Structure

- Shared package gf_mul_pkg: M, D, N, CNT_W = clog2(N), state encoding (IDLE=0, RUN=1). The delay registers and cells import the same package.
- One sub-module: gf_digit_shreg, parallel-load, D-bit left-shift register, M bits, async active-low reset, load and shift enables; its top D bits drive arr_b_dig.
- FSM, counter, framing flags and arr_a register live in gf_digit_feeder.

## Test plan

- Reset values: hold rst low, drive random inputs -> all outputs 0, in_ready 1; assert rst mid-RUN -> outputs clear in the same cycle without a clock edge.
- Single op: a=16'hA5C3, b=16'h1234, in_valid one cycle -> arr_b_dig 1,2,3,4 on four consecutive cycles, dig_first on 1, dig_last on 4, arr_a=16'hA5C3 throughout, then dig_valid 0 and arr_a still 16'hA5C3.
- Back-to-back: in_valid held high with b=16'h1234 then b=16'hFEDC -> digits 1,2,3,4,F,E,D,C contiguous, dig_first on 1 and F, in_ready high only in IDLE and on digits 4 and C.
- Stall: in_valid asserted on digit 2 of an op with b=16'hBEEF -> not accepted until digit 4 cycle; B digits follow immediately.
- Gap: second pair offered two cycles after dig_last -> dig_valid low for exactly two cycles, arr_b_dig 0 during them.
- Parameter sweep: M=16,D=8 with b=16'h55AA -> digits 8'h55, 8'hAA, dig_first and dig_last on consecutive cycles.
